vec_reg_file: RTL
=================

VEC_REG_FILE -- requirements
Module: vec_reg_file

Interface
REQ-001 Parameter element, default 16: lanes per vector and bits per lane.
REQ-002 Parameter regs, default 8: number of vector registers; power of two, at least 2.
REQ-003 Parameter AW, default $clog2(regs): register address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rd_addr_a  input  AW  register index driving vectorA.
REQ-007 rd_addr_b  input  AW  register index driving vectorB.
REQ-008 vectorA  output  [element-1:0][element-1:0]  operand A to the vector ALU.
REQ-009 vectorB  output  [element-1:0][element-1:0]  operand B to the vector ALU.
REQ-010 we  input  1  write request, ALU result writeback.
REQ-011 wr_addr  input  AW  destination register.
REQ-012 wr_data  input  [element-1:0][element-1:0]  ALU result vector.
REQ-013 wr_mask  input  element  per-lane write enable; bit i gates lane i.
REQ-014 clear_req  input  1  pulse requesting a sequential zeroing sweep of all registers.
REQ-015 busy  output  1  high while the clear sweep runs.

Function
REQ-016 Storage SHALL be regs x element lanes x element bits; lane i occupies bits [i] of the packed vector (lane element-1 is most significant).
REQ-017 Reads SHALL be combinational: vectorA/vectorB reflect the addressed register in the same cycle, zero latency.
REQ-018 Write SHALL commit on the rising edge when we=1 and state=IDLE: lane i of reg[wr_addr] <= wr_data[i] only where wr_mask[i]=1; unmasked lanes unchanged.
REQ-019 Bypass: in IDLE with we=1 and rd_addr_x==wr_addr, the read output SHALL return the merged value (wr_data on masked lanes, stored data elsewhere) in the same cycle.
REQ-020 Both read ports SHALL bypass independently; rd_addr_a==rd_addr_b==wr_addr gives identical outputs.
REQ-021 FSM states: IDLE, CLEAR; a 2-state machine with an AW-bit sweep counter cnt.
REQ-022 IDLE -> CLEAR on an edge where clear_req=1; cnt <= 0 on that edge; a write in that same cycle SHALL still commit.
REQ-023 In CLEAR, each edge SHALL zero reg[cnt] and increment cnt; on the edge with cnt==regs-1, state -> IDLE and cnt <= 0.
REQ-024 busy SHALL equal (state==CLEAR); it is high for exactly regs cycles per sweep.
REQ-025 While busy, we SHALL be ignored (write dropped, no bypass) and clear_req SHALL be ignored.
REQ-026 While busy, reads SHALL return current storage: already-cleared registers read zero, uncleared registers read old data.
REQ-027 No register is hardwired; reg[0] is writable like all others.
REQ-028 No arithmetic beyond counter increment; cnt wrap at regs-1 is explicit, not by overflow.

Reset
REQ-029 On an edge with rst=1, every register SHALL be zero, state=IDLE, cnt=0, busy=0, all in that single cycle.
REQ-030 rst SHALL take priority over we and clear_req on the same edge, and SHALL abort a sweep in progress.
REQ-031 After reset, vectorA/vectorB SHALL read all-zero for every address until written.

Verification
REQ-032 Reset, then we=1, wr_addr=3, wr_mask=16'hFFFF, wr_data=lane15..0 = 'hABCD,'hBA98,'h7654,'h3210, rest 0; next cycle rd_addr_a=3 -> vectorA equals that value.
REQ-033 Same cycle bypass: reg5 = all lanes 'h1111; write reg5 with wr_data all 'h2222, wr_mask=16'h00FF, rd_addr_b=5 -> vectorB lanes 7..0 = 'h2222, lanes 15..8 = 'h1111 in that cycle; identical value after the edge.
REQ-034 Fill all 8 registers with 'hFFFF, pulse clear_req -> busy high exactly 8 cycles; after k sweep edges, regs 0..k-1 read 0 and regs k..7 read 'hFFFF.
REQ-035 During sweep, assert we to reg7 with 'h1234 -> write dropped; reg7 reads 0 after sweep; clear_req pulse mid-sweep does not extend busy.
REQ-036 Assert rst on the 4th sweep cycle -> next cycle busy=0 and all registers read 0; a following write to reg2 commits normally.
REQ-037 clear_req and we to reg1 ('h00AA all lanes) on the same IDLE edge -> reg1 reads 'h00AA during the first busy cycle, then 0 after the second sweep edge.

Source files
------------

// File: rtl/vec_reg_file.sv
// Vector register file feeding a two-operand vector ALU.
// Two combinational read ports with same-cycle write bypass, one lane-masked
// write port for ALU writeback, and a background sweep that zeroes every
// register one per cycle on request.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | normal operation: writes commit, bypass active, clear_req accepted
// CLEAR | zeroing sweep: reg[cnt] cleared each edge, writes/clear_req ignored

module vec_reg_file #(
    parameter int element = 16,
    parameter int regs    = 8,
    parameter int AW      = $clog2(regs)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [AW-1:0]                    rd_addr_a,
    input  logic [AW-1:0]                    rd_addr_b,
    output logic [element-1:0][element-1:0]  vectorA,
    output logic [element-1:0][element-1:0]  vectorB,
    input  logic                             we,
    input  logic [AW-1:0]                    wr_addr,
    input  logic [element-1:0][element-1:0]  wr_data,
    input  logic [element-1:0]               wr_mask,
    input  logic                             clear_req,
    output logic                             busy
);

    typedef logic [element-1:0][element-1:0] vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Sweep terminates on this index; the wrap back to zero is explicit.
    localparam logic [AW-1:0] LAST = AW'(regs - 1);

    state_t        state;
    logic [AW-1:0] cnt;
    vec_t          mem [regs];
    vec_t          merged;
    logic          wr_en;

    // A write only lands (and only bypasses) while the sweep is not running.
    assign wr_en = we && (state == IDLE);

    // Destination register with the masked lanes replaced by the ALU result.
    always_comb begin
        merged = mem[wr_addr];
        for (int i = 0; i < element; i++) begin
            if (wr_mask[i]) begin
                merged[i] = wr_data[i];
            end
        end
    end

    // Read port A: forward the pending write when it targets the same register.
    always_comb begin
        if (wr_en && (rd_addr_a == wr_addr)) begin
            vectorA = merged;
        end else begin
            vectorA = mem[rd_addr_a];
        end
    end

    // Read port B: bypasses independently of port A.
    always_comb begin
        if (wr_en && (rd_addr_b == wr_addr)) begin
            vectorB = merged;
        end else begin
            vectorB = mem[rd_addr_b];
        end
    end

    // Storage: reset wipes everything at once, otherwise writeback or sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < regs; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= merged;
        end else if (state == CLEAR) begin
            mem[cnt] <= '0;
        end
    end

    // Sweep controller with busy registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + AW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
